// File: rtl/mandel_engine_pkg.sv
// Shared constants, FSM encoding and helpers for the Mandelbrot frame engine.
package mandel_engine_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 7;

  localparam int DEF_H_RES    = 640;
  localparam int DEF_V_RES    = 480;
  localparam int DEF_MAX_ITER = 127;
  localparam int DEF_WIDTH    = 18;
  localparam int DEF_FRAC     = 13;
  localparam int DEF_X_MIN    = -20480;
  localparam int DEF_Y_MAX    = 10800;
  localparam int DEF_STEP     = 45;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ITER  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // |z|^2 threshold of 4.0 expressed in the 2*FRAC fractional scale of the squares.
  function automatic longint esc_limit(input int frac);
    return longint'(4) <<< (2 * frac);
  endfunction

endpackage

// File: rtl/mandel_engine_if.sv
// BRAM write port driven by the engine toward the display stage's frame buffer.
interface mandel_engine_if;
  import mandel_engine_pkg::*;

  // Valid-only port: wea is the valid strobe and addr_w/dina are qualified by it in the
  // same cycle; there is no ready because the BRAM accepts a write every cycle.
  logic              wea;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] dina;

  modport master (output wea, addr_w, dina);
  modport slave  (input  wea, addr_w, dina);

endinterface

// File: rtl/mandel_engine_iter.sv
// One combinational Mandelbrot iteration: z' = z^2 + c plus the |z|^2 > 4 escape test.
module mandel_engine_iter
  import mandel_engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  output logic signed [WIDTH-1:0] zr_next,
  output logic signed [WIDTH-1:0] zi_next,
  output logic                    escape
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW:0] ESC_LIMIT = (PW+1)'(esc_limit(FRAC));

  logic signed [PW-1:0] rr;
  logic signed [PW-1:0] ii;
  logic signed [PW-1:0] ri;
  logic signed [PW:0]   mag;
  logic signed [PW:0]   diff;
  logic signed [PW:0]   dbl;

  assign rr   = PW'(zr) * PW'(zr);
  assign ii   = PW'(zi) * PW'(zi);
  assign ri   = PW'(zr) * PW'(zi);
  assign mag  = (PW+1)'(rr) + (PW+1)'(ii);
  assign diff = (PW+1)'(rr) - (PW+1)'(ii);
  assign dbl  = $signed({ri, 1'b0});

  assign escape = (mag > ESC_LIMIT);

  // Results stay within +/-16 while |z| <= 2, so truncating to WIDTH is lossless.
  assign zr_next = WIDTH'(diff >>> FRAC) + c_re;
  assign zi_next = WIDTH'(dbl >>> FRAC) + c_im;

endmodule

// File: rtl/mandel_engine.sv
// Raster-scans a frame, iterates each pixel to escape, and writes escape counts into the display BRAM.
module mandel_engine
  import mandel_engine_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int X_MIN    = DEF_X_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int STEP     = DEF_STEP
) (
  input  logic             CLK_100MHz,
  input  logic             reset_n,
  input  logic             start,
  mandel_engine_if.master  bram,
  output logic             read_enable,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0]            X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0]            Y_LAST  = YW'(V_RES - 1);
  localparam logic [DATA_W-1:0]        N_MAX   = DATA_W'(MAX_ITER);
  localparam logic signed [WIDTH-1:0]  X_MIN_W = WIDTH'(X_MIN);
  localparam logic signed [WIDTH-1:0]  Y_MAX_W = WIDTH'(Y_MAX);
  localparam logic signed [WIDTH-1:0]  STEP_W  = WIDTH'(STEP);

  state_t state;
  state_t state_next;

  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        n;
  logic signed [WIDTH-1:0]  zr;
  logic signed [WIDTH-1:0]  zi;
  logic signed [WIDTH-1:0]  c_re;
  logic signed [WIDTH-1:0]  c_im;
  logic signed [WIDTH-1:0]  zr_next;
  logic signed [WIDTH-1:0]  zi_next;
  logic                     escape;
  logic                     frame_start;
  logic                     iter_stop;
  logic                     last_pix;

  mandel_engine_iter #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_iter (
    .zr      (zr),
    .zi      (zi),
    .c_re    (c_re),
    .c_im    (c_im),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escape  (escape)
  );

  assign frame_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign iter_stop   = escape || (n == N_MAX);
  assign last_pix    = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge CLK_100MHz or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_INIT;
      S_INIT:  state_next = S_ITER;
      S_ITER:  if (iter_stop) state_next = S_WRITE;
      S_WRITE: state_next = last_pix ? S_DONE : S_INIT;
      S_DONE:  if (start) state_next = S_INIT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
      n    <= '0;
      zr   <= '0;
      zi   <= '0;
      c_re <= X_MIN_W;
      c_im <= Y_MAX_W;
    end else begin
      if (frame_start) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
        c_re <= X_MIN_W;
        c_im <= Y_MAX_W;
      end
      case (state)
        S_INIT: begin
          zr <= '0;
          zi <= '0;
          n  <= '0;
        end
        S_ITER: begin
          // On escape z is frozen so n stays the count that gets written.
          if (!iter_stop) begin
            zr <= zr_next;
            zi <= zi_next;
            n  <= n + 1'b1;
          end
        end
        S_WRITE: begin
          if (!last_pix) begin
            addr <= addr + 1'b1;
            if (x == X_LAST) begin
              x    <= '0;
              y    <= y + 1'b1;
              c_re <= X_MIN_W;
              c_im <= c_im - STEP_W;
            end else begin
              x    <= x + 1'b1;
              c_re <= c_re + STEP_W;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bram.wea    = (state == S_WRITE);
  assign bram.addr_w = addr;
  assign bram.dina   = n;
  assign busy        = (state == S_INIT) || (state == S_ITER) || (state == S_WRITE);
  assign read_enable = (state == S_DONE);
  assign state_dbg   = state;

endmodule
